// File: rtl/imem_pkg.sv
// Shared constants for the instruction fetch path: fault encodings and
// default text-segment placement.
package imem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10
  } fault_e;

  localparam logic [31:0] DEF_BASE_ADDR  = 32'h0040_0000;
  localparam logic [31:0] DEF_FAULT_WORD = 32'h0000_0000;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Two-entry response buffer. e0 is always the head; on an empty pop the head
// keeps its last value so the rsp_* outputs stay stable.
module imem_rsp_fifo #(
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] e0, e1;
  logic             do_push, do_pop;

  assign do_pop  = pop & (count != 2'd0);
  assign do_push = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) e0 <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // count is 1 or 2 here; count stays put
          if (count == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = e0;

endmodule

// File: rtl/program_memory_fetch.sv
// Instruction ROM behind a valid/ready fetch port: decodes text-segment byte
// addresses, flags misaligned/out-of-range fetches, buffers two responses.
module program_memory_fetch
  import imem_pkg::*;
#(
  parameter int                         MEMORY_DEPTH = 64,
  parameter int                         DATA_WIDTH   = 32,
  parameter int                         ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR    = ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter logic [DATA_WIDTH-1:0]      FAULT_WORD   = DATA_WIDTH'(DEF_FAULT_WORD),
  // ROM image, element k is the word at BASE_ADDR + 4*k
  parameter logic [MEMORY_DEPTH-1:0][DATA_WIDTH-1:0] INIT_IMAGE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [1:0]            rsp_fault,
  output logic                  fault_sticky
);

  localparam int IDX_W = $clog2(MEMORY_DEPTH);
  localparam int FW    = ADDR_WIDTH + DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(4 * MEMORY_DEPTH);

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] instr;
  fault_e                fault;
  logic [FW-1:0]         din, dout;
  logic [1:0]            count;
  logic                  push, pop;

  assign offset = req_addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

  always_comb begin
    fault = FAULT_NONE;
    instr = INIT_IMAGE[idx];
    if (req_addr[1:0] != 2'b00) begin
      fault = FAULT_MISALIGN;
      instr = FAULT_WORD;
    end else if ((req_addr < BASE_ADDR) || (offset >= SPAN)) begin
      fault = FAULT_RANGE;
      instr = FAULT_WORD;
    end
  end

  // ready depends only on buffer occupancy and flush, never on rsp_ready
  assign req_ready = (count != 2'd2) & ~flush;
  assign push      = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;
  assign din       = {req_addr, instr, fault};

  imem_rsp_fifo #(.WIDTH(FW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count)
  );

  assign rsp_valid = (count != 2'd0);
  assign rsp_addr  = dout[FW-1 -: ADDR_WIDTH];
  assign rsp_instr = dout[DATA_WIDTH+1 -: DATA_WIDTH];
  assign rsp_fault = dout[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                          fault_sticky <= 1'b0;
    else if (pop && !flush && (rsp_fault != FAULT_NONE)) fault_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_program_memory_fetch.sv
// Directed bench for program_memory_fetch with a response scoreboard.
module tb_program_memory_fetch;

  function automatic logic [63:0][31:0] gen_img();
    logic [63:0][31:0] img;
    for (int k = 0; k < 64; k++) img[k] = 32'h2000_0000 + 32'(k);
    return img;
  endfunction

  localparam logic [63:0][31:0] IMG = gen_img();

  logic        clk = 1'b0;
  logic        reset, flush, req_valid, rsp_ready;
  logic [31:0] req_addr;
  logic        req_ready, rsp_valid, fault_sticky;
  logic [31:0] rsp_instr, rsp_addr;
  logic [1:0]  rsp_fault;

  int n_assert = 0;
  int n_fail   = 0;
  logic [65:0] sb[$];

  program_memory_fetch #(
    .MEMORY_DEPTH (64),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .BASE_ADDR    (32'h0040_0000),
    .FAULT_WORD   (32'h0000_0000),
    .INIT_IMAGE   (IMG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_instr    (rsp_instr),
    .rsp_addr     (rsp_addr),
    .rsp_fault    (rsp_fault),
    .fault_sticky (fault_sticky)
  );

  always #5 clk = ~clk;

  // expected {addr, instr, fault} for a fetch of address a
  function automatic logic [65:0] model(input logic [31:0] a);
    if (a[1:0] != 2'b00) return {a, 32'h0, 2'b01};
    if (a < 32'h0040_0000 || a >= 32'h0040_0100) return {a, 32'h0, 2'b10};
    return {a, 32'h2000_0000 + ((a - 32'h0040_0000) >> 2), 2'b00};
  endfunction

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: pops checked on the handshake, pushes on acceptance
  always @(negedge clk) begin
    if (!reset || flush) sb.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("sb_underflow", 66'd1, 66'd0);
        else check("sb_rsp", {rsp_addr, rsp_instr, rsp_fault}, sb.pop_front());
      end
      if (req_valid && req_ready) sb.push_back(model(req_addr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    #3;
    check("rst_valid",  rsp_valid, 0);
    check("rst_instr",  rsp_instr, 0);
    check("rst_addr",   rsp_addr, 0);
    check("rst_fault",  rsp_fault, 0);
    check("rst_sticky", fault_sticky, 0);
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("rst_ready", req_ready, 1);

    // back-to-back fetches with consumer always ready
    step(); rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0040_0000;
    @(negedge clk); check("b2b_rdy0", req_ready, 1); check("b2b_vld0", rsp_valid, 0);
    step(); req_addr = 32'h0040_0004;
    @(negedge clk); check("b2b_rdy1", req_ready, 1); check("b2b_i0", rsp_instr, 32'h2000_0000);
    step(); req_addr = 32'h0040_0008;
    @(negedge clk); check("b2b_rdy2", req_ready, 1); check("b2b_i1", rsp_instr, 32'h2000_0001);
    step(); req_valid = 1'b0;
    @(negedge clk); check("b2b_i2", rsp_instr, 32'h2000_0002); check("b2b_vld2", rsp_valid, 1);
    step();
    @(negedge clk); check("b2b_empty", rsp_valid, 0);

    // misaligned fetch and sticky flag
    step(); req_valid = 1'b1; req_addr = 32'h0040_0002;
    step(); req_valid = 1'b0;
    @(negedge clk);
    check("mis_fault", rsp_fault, 2'b01);
    check("mis_instr", rsp_instr, 0);
    check("mis_addr", rsp_addr, 32'h0040_0002);
    check("mis_sticky_pre", fault_sticky, 0);
    step();
    @(negedge clk); check("mis_sticky", fault_sticky, 1);

    // out-of-range: one past the top, one below the base
    step(); req_valid = 1'b1; req_addr = 32'h0040_0100;
    step(); req_addr = 32'h003F_FFFC;
    @(negedge clk); check("rng_hi_fault", rsp_fault, 2'b10); check("rng_hi_instr", rsp_instr, 0);
    step(); req_valid = 1'b0;
    @(negedge clk); check("rng_lo_fault", rsp_fault, 2'b10); check("rng_lo_addr", rsp_addr, 32'h003F_FFFC);
    step();
    @(negedge clk); check("rng_empty", rsp_valid, 0); check("sticky_hold", fault_sticky, 1);

    // stall: third request waits until the buffer drains
    step(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0040_0000;
    step(); req_addr = 32'h0040_0004;
    step(); req_addr = 32'h0040_0008;
    @(negedge clk); check("stl_rdy_full", req_ready, 0); check("stl_head", rsp_instr, 32'h2000_0000);
    step();
    @(negedge clk); check("stl_rdy_hold", req_ready, 0);
    step(); rsp_ready = 1'b1;
    @(negedge clk); check("stl_rdy_rel", req_ready, 0); check("stl_i0", rsp_instr, 32'h2000_0000);
    step();
    @(negedge clk); check("stl_i1", rsp_instr, 32'h2000_0001); check("stl_rdy1", req_ready, 1);
    step(); req_valid = 1'b0;
    @(negedge clk); check("stl_i2", rsp_instr, 32'h2000_0002); check("stl_vld2", rsp_valid, 1);
    step();
    @(negedge clk); check("stl_empty", rsp_valid, 0);

    // flush with two buffered entries and a concurrent request
    step(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0040_000C;
    step(); req_addr = 32'h0040_0010;
    step(); req_addr = 32'h0040_0014; flush = 1'b1;
    @(negedge clk); check("fl_rdy", req_ready, 0); check("fl_vld_pre", rsp_valid, 1);
    step(); flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("fl_vld", rsp_valid, 0);
    check("fl_rdy_after", req_ready, 1);
    check("fl_head_hold", rsp_instr, 32'h2000_0003);
    step(); rsp_ready = 1'b1;
    @(negedge clk); check("fl_stays_empty", rsp_valid, 0);

    // async reset mid-stream with a full buffer
    step(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0040_0000;
    step(); req_addr = 32'h0040_0004;
    step(); req_valid = 1'b0;
    check("ar_vld_pre", rsp_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("ar_vld", rsp_valid, 0);
    check("ar_sticky", fault_sticky, 0);
    check("ar_instr", rsp_instr, 0);
    check("ar_rdy", req_ready, 1);
    @(negedge clk); #1 reset = 1'b1;
    step(); rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0040_000C;
    step(); req_valid = 1'b0;
    @(negedge clk);
    check("ar_i3", rsp_instr, 32'h2000_0003);
    check("ar_fault", rsp_fault, 0);
    check("ar_sticky_post", fault_sticky, 0);
    step();
    @(negedge clk); check("ar_empty", rsp_valid, 0);

    // a faulted head popped during flush must not set the sticky flag
    step(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0040_0001;
    step(); req_valid = 1'b0;
    @(negedge clk); check("fp_fault", rsp_fault, 2'b01); check("fp_vld", rsp_valid, 1);
    step(); flush = 1'b1; rsp_ready = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk); check("fp_sticky", fault_sticky, 0); check("fp_vld_after", rsp_valid, 0);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
